// File: rtl/pipe_ctrl_unit.sv
// RV32I five-stage pipeline control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, hazard detection, operand forwarding, EX branch resolution and perf counters.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_id,
  input  logic                  valid_id,
  input  logic                  br_eq_ex,
  input  logic                  br_lt_ex,
  output logic [2:0]            imm_sel_id,
  output logic                  illegal_id,
  output logic                  stall_if,
  output logic                  flush_ifid,
  output logic                  a_sel_ex,
  output logic                  b_sel_ex,
  output logic [3:0]            alu_sel_ex,
  output logic                  br_un_ex,
  output logic                  pc_sel_ex,
  output logic [1:0]            fwd_a_ex,
  output logic [1:0]            fwd_b_ex,
  output logic                  mem_wr_mem,
  output logic                  mem_rd_mem,
  output logic [2:0]            funct3_mem,
  output logic                  reg_wen_wb,
  output logic [1:0]            wb_sel_wb,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int STAGES = 3;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_U = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PCIMM = 4'd10;
  localparam logic [3:0] ALU_IMM   = 4'd11;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic                  a_sel;
    logic                  b_sel;
    logic [3:0]            alu_sel;
    logic                  br_un;
    logic                  is_br;
    logic                  is_jmp;
    logic [2:0]            funct3;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  reg_wen;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } idex_t;

  typedef struct packed {
    logic                  mem_rd;
    logic                  mem_wr;
    logic [2:0]            funct3;
    logic                  reg_wen;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                  reg_wen;
    logic [1:0]            wb_sel;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [4:0]            opc;
  logic [2:0]            f3;
  logic                  f7b5;
  logic [REG_ADDR_W-1:0] rd_f, rs1_f, rs2_f;
  logic                  unused_instr;

  assign opc   = instr_id[6:2];
  assign f3    = instr_id[14:12];
  assign f7b5  = instr_id[30];
  assign rd_f  = REG_ADDR_W'(instr_id[11:7]);
  assign rs1_f = REG_ADDR_W'(instr_id[19:15]);
  assign rs2_f = REG_ADDR_W'(instr_id[24:20]);
  assign unused_instr = ^{instr_id[31], instr_id[29:25], instr_id[1:0]};

  idex_t      dec, ex_q, ex_d;
  exmem_t     mem_q;
  memwb_t     wb_q;
  logic       legal, use1, use2;
  logic [2:0] imm_sel;
  logic [STAGES-1:0] vld_pipe;

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    imm_sel = IMM_I;
    use1    = 1'b0;
    use2    = 1'b0;
    dec.funct3 = f3;
    dec.rd     = rd_f;
    case (opc)
      OPC_LOAD: begin
        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        dec.b_sel = 1'b1; dec.mem_rd = 1'b1; dec.reg_wen = 1'b1; dec.wb_sel = WB_MEM;
        use1 = 1'b1;
      end
      OPC_OPIMM: begin
        legal = 1'b1;
        dec.b_sel = 1'b1; dec.alu_sel = alu_of(f3, f7b5 & (f3 == 3'd5));
        dec.reg_wen = 1'b1; dec.wb_sel = WB_ALU;
        use1 = 1'b1;
      end
      OPC_OP: begin
        legal = 1'b1;
        dec.alu_sel = alu_of(f3, f7b5 & ((f3 == 3'd0) || (f3 == 3'd5)));
        dec.reg_wen = 1'b1; dec.wb_sel = WB_ALU;
        use1 = 1'b1; use2 = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; imm_sel = IMM_U;
        dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.alu_sel = ALU_PCIMM;
        dec.reg_wen = 1'b1; dec.wb_sel = WB_ALU;
      end
      OPC_LUI: begin
        legal = 1'b1; imm_sel = IMM_U;
        dec.b_sel = 1'b1; dec.alu_sel = ALU_IMM;
        dec.reg_wen = 1'b1; dec.wb_sel = WB_ALU;
      end
      OPC_STORE: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        imm_sel = IMM_S;
        dec.b_sel = 1'b1; dec.mem_wr = 1'b1;
        use1 = 1'b1; use2 = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        imm_sel = IMM_B;
        dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.is_br = 1'b1; dec.br_un = f3[1];
        use1 = 1'b1; use2 = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; imm_sel = IMM_J;
        dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.is_jmp = 1'b1;
        dec.reg_wen = 1'b1; dec.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0);
        dec.b_sel = 1'b1; dec.is_jmp = 1'b1;
        dec.reg_wen = 1'b1; dec.wb_sel = WB_PC4;
        use1 = 1'b1;
      end
      default: ;
    endcase
    if (rd_f == '0) dec.reg_wen = 1'b0;
    // Unused source fields are zeroed so hazard/forward compares never match them.
    dec.rs1 = use1 ? rs1_f : '0;
    dec.rs2 = use2 ? rs2_f : '0;
  end

  logic id_ok, hit_ex, hit_mem, load_use, raw_stall, hazard, taken, id_acc;

  assign id_ok      = valid_id & legal;
  assign imm_sel_id = valid_id ? imm_sel : IMM_I;
  assign illegal_id = valid_id & ~legal;

  assign hit_ex  = (ex_q.rd != '0)  && ((dec.rs1 == ex_q.rd)  || (dec.rs2 == ex_q.rd));
  assign hit_mem = (mem_q.rd != '0) && ((dec.rs1 == mem_q.rd) || (dec.rs2 == mem_q.rd));

  assign load_use  = id_ok & ex_q.mem_rd & hit_ex;
  assign raw_stall = !FWD_EN && id_ok && ((ex_q.reg_wen && hit_ex) || (mem_q.reg_wen && hit_mem));
  assign hazard    = load_use | raw_stall;

  // funct3[2] picks lt vs eq, funct3[0] inverts (BNE/BGE/BGEU).
  assign taken     = ex_q.is_br & ((ex_q.funct3[2] ? br_lt_ex : br_eq_ex) ^ ex_q.funct3[0]);
  assign pc_sel_ex = vld_pipe[0] & (taken | ex_q.is_jmp);

  assign flush_ifid = pc_sel_ex;
  assign stall_if   = hazard & ~pc_sel_ex;
  assign id_acc     = id_ok & ~hazard & ~pc_sel_ex;
  assign ex_d       = id_acc ? dec : '0;

  always_comb begin
    fwd_a_ex = 2'd0;
    fwd_b_ex = 2'd0;
    if (FWD_EN) begin
      if (mem_q.reg_wen && mem_q.rd == ex_q.rs1 && ex_q.rs1 != '0)     fwd_a_ex = 2'd2;
      else if (wb_q.reg_wen && wb_q.rd == ex_q.rs1 && ex_q.rs1 != '0) fwd_a_ex = 2'd1;
      if (mem_q.reg_wen && mem_q.rd == ex_q.rs2 && ex_q.rs2 != '0)     fwd_b_ex = 2'd2;
      else if (wb_q.reg_wen && wb_q.rd == ex_q.rs2 && ex_q.rs2 != '0) fwd_b_ex = 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-2:0], id_acc};
      ex_q         <= ex_d;
      mem_q.mem_rd  <= ex_q.mem_rd;
      mem_q.mem_wr  <= ex_q.mem_wr;
      mem_q.funct3  <= vld_pipe[0] ? ex_q.funct3 : 3'd0;
      mem_q.reg_wen <= ex_q.reg_wen;
      mem_q.wb_sel  <= ex_q.wb_sel;
      mem_q.rd      <= ex_q.rd;
      wb_q.reg_wen  <= mem_q.reg_wen;
      wb_q.wb_sel   <= mem_q.wb_sel;
      wb_q.rd       <= mem_q.rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_sel_ex && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign a_sel_ex   = ex_q.a_sel;
  assign b_sel_ex   = ex_q.b_sel;
  assign alu_sel_ex = ex_q.alu_sel;
  assign br_un_ex   = ex_q.br_un;
  assign mem_wr_mem = vld_pipe[1] & mem_q.mem_wr;
  assign mem_rd_mem = vld_pipe[1] & mem_q.mem_rd;
  assign funct3_mem = mem_q.funct3;
  assign reg_wen_wb = vld_pipe[2] & wb_q.reg_wen;
  assign wb_sel_wb  = wb_q.wb_sel;
  assign rd_wb      = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode vector table plus hand-timed hazard,
// forwarding, flush and reset sequences on a forwarding and a non-forwarding instance.
module tb_pipe_ctrl_unit;
  logic        clk, rst;
  logic [31:0] instr_id;
  logic        valid_id, br_eq_ex, br_lt_ex;

  logic [2:0]  imm_sel_id, imm_sel_id0;
  logic        illegal_id, illegal_id0, stall_if, stall_if0, flush_ifid, flush_ifid0;
  logic        a_sel_ex, a_sel_ex0, b_sel_ex, b_sel_ex0;
  logic [3:0]  alu_sel_ex, alu_sel_ex0;
  logic        br_un_ex, br_un_ex0, pc_sel_ex, pc_sel_ex0;
  logic [1:0]  fwd_a_ex, fwd_a_ex0, fwd_b_ex, fwd_b_ex0;
  logic        mem_wr_mem, mem_wr_mem0, mem_rd_mem, mem_rd_mem0;
  logic [2:0]  funct3_mem, funct3_mem0;
  logic        reg_wen_wb, reg_wen_wb0;
  logic [1:0]  wb_sel_wb, wb_sel_wb0;
  logic [4:0]  rd_wb, rd_wb0;
  logic [31:0] stall_cnt, stall_cnt0, flush_cnt, flush_cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
    .br_eq_ex(br_eq_ex), .br_lt_ex(br_lt_ex), .imm_sel_id(imm_sel_id),
    .illegal_id(illegal_id), .stall_if(stall_if), .flush_ifid(flush_ifid),
    .a_sel_ex(a_sel_ex), .b_sel_ex(b_sel_ex), .alu_sel_ex(alu_sel_ex),
    .br_un_ex(br_un_ex), .pc_sel_ex(pc_sel_ex), .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
    .mem_wr_mem(mem_wr_mem), .mem_rd_mem(mem_rd_mem), .funct3_mem(funct3_mem),
    .reg_wen_wb(reg_wen_wb), .wb_sel_wb(wb_sel_wb), .rd_wb(rd_wb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_ctrl_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
    .br_eq_ex(br_eq_ex), .br_lt_ex(br_lt_ex), .imm_sel_id(imm_sel_id0),
    .illegal_id(illegal_id0), .stall_if(stall_if0), .flush_ifid(flush_ifid0),
    .a_sel_ex(a_sel_ex0), .b_sel_ex(b_sel_ex0), .alu_sel_ex(alu_sel_ex0),
    .br_un_ex(br_un_ex0), .pc_sel_ex(pc_sel_ex0), .fwd_a_ex(fwd_a_ex0), .fwd_b_ex(fwd_b_ex0),
    .mem_wr_mem(mem_wr_mem0), .mem_rd_mem(mem_rd_mem0), .funct3_mem(funct3_mem0),
    .reg_wen_wb(reg_wen_wb0), .wb_sel_wb(wb_sel_wb0), .rd_wb(rd_wb0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] LW    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD5  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] SUB4  = 32'h40118233; // sub  x4,x3,x1
  localparam logic [31:0] BEQ   = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] ILL   = 32'h0000007F;
  localparam logic [31:0] ADDI0 = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADDX0 = 32'h001002B3; // add  x5,x0,x1
  localparam logic [31:0] SW    = 32'h0020A023; // sw   x2,0(x1)
  localparam logic [31:0] JAL   = 32'h010000EF; // jal  x1,16

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        eq, lt;
    logic [2:0]  imm;
    logic        ill, a, b;
    logic [3:0]  alu;
    logic        brun, pc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_id = 1'b0; br_eq_ex = 1'b0; br_lt_ex = 1'b0; instr_id = '0;
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    int nst;
    logic wen_seen;
    //            name     instr         eq lt imm  ill a  b  alu   un pc
    tbl[0]  = '{"lw",    32'h0000A283, 0, 0, 3'd0, 0, 0, 1, 4'd0,  0, 0};
    tbl[1]  = '{"add",   32'h002081B3, 0, 0, 3'd0, 0, 0, 0, 4'd0,  0, 0};
    tbl[2]  = '{"sub",   32'h40118233, 0, 0, 3'd0, 0, 0, 0, 4'd1,  0, 0};
    tbl[3]  = '{"xori",  32'h0050C393, 0, 0, 3'd0, 0, 0, 1, 4'd4,  0, 0};
    tbl[4]  = '{"srai",  32'h4030D393, 0, 0, 3'd0, 0, 0, 1, 4'd7,  0, 0};
    tbl[5]  = '{"lui",   32'h123452B7, 0, 0, 3'd1, 0, 0, 1, 4'd11, 0, 0};
    tbl[6]  = '{"auipc", 32'h00001297, 0, 0, 3'd1, 0, 1, 1, 4'd10, 0, 0};
    tbl[7]  = '{"sw",    32'h0020A023, 0, 0, 3'd2, 0, 0, 1, 4'd0,  0, 0};
    tbl[8]  = '{"bltu",  32'h0020E463, 0, 1, 3'd3, 0, 1, 1, 4'd0,  1, 1};
    tbl[9]  = '{"bge",   32'h0020D463, 0, 1, 3'd3, 0, 1, 1, 4'd0,  0, 0};
    tbl[10] = '{"jal",   32'h010000EF, 0, 0, 3'd4, 0, 1, 1, 4'd0,  0, 1};
    tbl[11] = '{"jalr",  32'h00008067, 0, 0, 3'd0, 0, 0, 1, 4'd0,  0, 1};
    tbl[12] = '{"ill7f", 32'h0000007F, 0, 0, 3'd0, 1, 0, 0, 4'd0,  0, 0};
    tbl[13] = '{"ldf3",  32'h0000B283, 0, 0, 3'd0, 1, 0, 0, 4'd0,  0, 0};
    tbl[14] = '{"bne",   32'h00209463, 1, 0, 3'd3, 0, 1, 1, 4'd0,  0, 0};

    rst = 1'b1; valid_id = 1'b0; instr_id = '0; br_eq_ex = 1'b0; br_lt_ex = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_if, 0);
    chk("rst_flush", flush_ifid, 0);
    chk("rst_pcsel", pc_sel_ex, 0);
    chk("rst_wen", reg_wen_wb, 0);
    chk("rst_rd", rd_wb, 0);
    chk("rst_memwr", mem_wr_mem, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    rst = 1'b0;

    // Decode table: ID outputs in cycle n, EX controls in cycle n+1.
    for (int i = 0; i < 15; i++) begin
      next_cyc();
      instr_id = tbl[i].instr; valid_id = 1'b1;
      br_eq_ex = tbl[i].eq; br_lt_ex = tbl[i].lt;
      @(negedge clk);
      chk({tbl[i].name, "_imm"}, imm_sel_id, tbl[i].imm);
      chk({tbl[i].name, "_ill"}, illegal_id, tbl[i].ill);
      next_cyc();
      valid_id = 1'b0;
      @(negedge clk);
      chk({tbl[i].name, "_asel"}, a_sel_ex, tbl[i].a);
      chk({tbl[i].name, "_bsel"}, b_sel_ex, tbl[i].b);
      chk({tbl[i].name, "_alu"}, alu_sel_ex, tbl[i].alu);
      chk({tbl[i].name, "_brun"}, br_un_ex, tbl[i].brun);
      chk({tbl[i].name, "_pcsel"}, pc_sel_ex, tbl[i].pc);
    end
    chk("tbl_fcnt", flush_cnt, 3);
    chk("tbl_scnt", stall_cnt, 0);

    // Load-use with forwarding: one stall, then WB forward to rs1.
    next_cyc(); do_reset();
    instr_id = LW; valid_id = 1'b1;
    @(negedge clk); chk("lu_nostall0", stall_if, 0);
    next_cyc(); instr_id = ADD5;
    @(negedge clk); chk("lu_stall", stall_if, 1);
    next_cyc();
    @(negedge clk); chk("lu_release", stall_if, 0);
    next_cyc(); valid_id = 1'b0;
    @(negedge clk);
    chk("lu_fwd_a", fwd_a_ex, 1);
    chk("lu_fwd_b", fwd_b_ex, 0);
    chk("lu_scnt", stall_cnt, 1);

    // ALU-to-ALU forwarding from MEM.
    next_cyc(); do_reset();
    instr_id = ADD3; valid_id = 1'b1;
    next_cyc(); instr_id = SUB4;
    @(negedge clk); chk("aa_nostall", stall_if, 0);
    next_cyc(); valid_id = 1'b0;
    @(negedge clk);
    chk("aa_fwd_a", fwd_a_ex, 2);
    chk("aa_fwd_b", fwd_b_ex, 0);
    chk("aa_alu", alu_sel_ex, 1);

    // Same pair without forwarding: stall until producer reaches WB.
    next_cyc(); do_reset();
    instr_id = ADD3; valid_id = 1'b1;
    next_cyc(); instr_id = SUB4;
    nst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!stall_if0) break;
      nst++;
      next_cyc();
    end
    next_cyc(); valid_id = 1'b0;
    @(negedge clk);
    chk("nf_stall_cycles", nst, 2);
    chk("nf_fwd_a", fwd_a_ex0, 0);
    chk("nf_fwd_b", fwd_b_ex0, 0);
    chk("nf_alu", alu_sel_ex0, 1);
    chk("nf_scnt", stall_cnt0, 2);

    // Taken BEQ: flush one cycle, younger instructions never write.
    next_cyc(); do_reset();
    instr_id = BEQ; valid_id = 1'b1;
    next_cyc(); instr_id = ADD3; br_eq_ex = 1'b1;
    @(negedge clk);
    chk("bt_pcsel", pc_sel_ex, 1);
    chk("bt_flush", flush_ifid, 1);
    chk("bt_stall", stall_if, 0);
    next_cyc(); valid_id = 1'b0; br_eq_ex = 1'b0;
    @(negedge clk);
    chk("bt_flush_once", flush_ifid, 0);
    wen_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      @(negedge clk);
      if (reg_wen_wb || mem_wr_mem) wen_seen = 1'b1;
    end
    chk("bt_no_write", wen_seen, 0);
    chk("bt_fcnt", flush_cnt, 1);

    // Not-taken BEQ: younger add completes.
    next_cyc(); do_reset();
    instr_id = BEQ; valid_id = 1'b1;
    next_cyc(); instr_id = ADD3; br_eq_ex = 1'b0;
    @(negedge clk);
    chk("bn_pcsel", pc_sel_ex, 0);
    chk("bn_flush", flush_ifid, 0);
    next_cyc(); valid_id = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("bn_wen", reg_wen_wb, 1);
    chk("bn_rd", rd_wb, 3);
    chk("bn_wbsel", wb_sel_wb, 1);
    chk("bn_fcnt", flush_cnt, 0);

    // Illegal opcode: flagged in ID, no write three cycles later.
    next_cyc(); do_reset();
    instr_id = ILL; valid_id = 1'b1;
    @(negedge clk); chk("il_flag", illegal_id, 1);
    next_cyc(); valid_id = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk); chk("il_no_wen", reg_wen_wb, 0);

    // Writes to x0 are neither forwarded nor written back.
    next_cyc(); do_reset();
    instr_id = ADDI0; valid_id = 1'b1;
    next_cyc(); instr_id = ADDX0;
    @(negedge clk); chk("x0_nostall", stall_if, 0);
    next_cyc(); valid_id = 1'b0;
    @(negedge clk);
    chk("x0_fwd_a", fwd_a_ex, 0);
    chk("x0_fwd_b", fwd_b_ex, 0);
    next_cyc();
    @(negedge clk); chk("x0_no_wen", reg_wen_wb, 0);
    next_cyc();
    @(negedge clk);
    chk("x0_add_wen", reg_wen_wb, 1);
    chk("x0_add_rd", rd_wb, 5);

    // Reset while a store sits in MEM.
    next_cyc(); do_reset();
    instr_id = JAL; valid_id = 1'b1;
    next_cyc(); valid_id = 1'b0;
    next_cyc(); instr_id = SW; valid_id = 1'b1;
    next_cyc(); valid_id = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("mr_memwr_pre", mem_wr_mem, 1);
    chk("mr_f3_pre", funct3_mem, 2);
    chk("mr_fcnt_pre", flush_cnt, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_memwr", mem_wr_mem, 0);
    chk("mr_f3", funct3_mem, 0);
    chk("mr_fcnt", flush_cnt, 0);
    chk("mr_scnt", stall_cnt, 0);
    chk("mr_wen", reg_wen_wb, 0);
    chk("mr_pcsel", pc_sel_ex, 0);
    chk("mr_alu", alu_sel_ex, 0);
    next_cyc(); rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised five-stage control unit for the RV32I pipeline. It decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and RAW hazards, drives the operand-forwarding selects, resolves branches and jumps in EX, and raises flushes and stalls. It sits beside the datapath pipeline registers and replaces per-stage combinational decode.

## Interface
- REG_ADDR_W, 5, register-index width (rd/rs1/rs2).
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on every RAW hazard until the producer retires.
- CNT_W, 32, width of the stall and flush performance counters.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- instr_id  in  32  instruction held in the IF/ID register.
- valid_id  in  1  IF/ID holds a real instruction.
- br_eq_ex, br_lt_ex  in  1  comparator results for the EX operands, computed using br_un_ex.
- imm_sel_id  out  3  immediate type: 0=I, 1=U, 2=S, 3=B, 4=J.
- illegal_id  out  1  valid_id is high and the opcode/funct3 combination is unsupported.
- stall_if  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  load a bubble into IF/ID at the next edge.
- a_sel_ex, b_sel_ex  out  1  ALU operand selects: A 1=PC, B 1=imm.
- alu_sel_ex  out  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 pc+imm, 11 pass imm.
- br_un_ex  out  1  unsigned compare.
- pc_sel_ex  out  1  redirect PC to the ALU result.
- fwd_a_ex, fwd_b_ex  out  2  operand source: 0 = regfile, 1 = WB result, 2 = MEM ALU result.
- mem_wr_mem, mem_rd_mem  out  1  data-memory store and load strobes.
- funct3_mem  out  3  access size and sign for the LSU.
- reg_wen_wb  out  1  register write enable (never asserted for rd=0).
- wb_sel_wb  out  2  write-back source: 0 = mem, 1 = ALU, 2 = PC+4.
- rd_wb  out  REG_ADDR_W  destination register.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Decode uses opcode = instr[6:2], funct3 = instr[14:12] and funct7b5 = instr[30].
- Supported instruction classes: LB/LH/LW/LBU/LHU, OP-IMM, OP, AUIPC, LUI, SB/SH/SW, all six branches, JAL and JALR.
- Branches always use ImmSel=3, a_sel=1, b_sel=1 and alu_sel=0. Taken conditions evaluated in EX:
  - BEQ: br_eq.
  - BNE: !br_eq.
  - BLT and BLTU: br_lt.
  - BGE and BGEU: !br_lt.
  - br_un=1 for BLTU and BGEU.
- pc_sel_ex = EX valid and (branch taken, or JAL, or JALR).
- Illegal or invalid instructions enter ID/EX as a bubble. A bubble has all control bits 0 and valid=0.
- Usage flags: uses_rs1 is false for LUI, AUIPC and JAL. uses_rs2 is true only for OP, store and branch instructions.
- Load-use hazard: EX holds a load with rd≠0, and rd equals a used rs of the ID instruction.
  - Response: stall_if=1 for 1 cycle and a bubble is inserted into ID/EX.
- FWD_EN=0: also stall while a used rs matches a nonzero rd with reg_wen in EX or MEM.
  - The regfile is write-through, so a match in WB needs no stall.
- Forwarding (FWD_EN=1), evaluated per operand:
  - 2 if the MEM stage has reg_wen, rd≠0 and rd equals the EX rs.
  - Else 1 if the same conditions hold for the WB stage.
  - Else 0.
  - MEM has priority over WB.
  - With FWD_EN=0, both selects are held at 0.
- Flush: when pc_sel_ex=1, flush_ifid=1 and ID/EX receives a bubble at the next edge. Flush overrides stall.
- Counters:
  - stall_cnt increments on each cycle with stall_if=1 and not flushed.
  - flush_cnt increments on each cycle with pc_sel_ex=1.
  - Both saturate at all-ones.

## Timing
- Reset: all pipeline control registers hold bubbles, so every output is 0, counters are 0 and rd_wb=0. Reset mid-operation discards all in-flight instructions within the same cycle, with no writes.
- Decode, hazard, forward and pc_sel logic is combinational from instr_id, the pipeline registers and br_*_ex. All stage registers update on the rising edge of clk.
- Latency: an instruction accepted in ID at cycle n has EX controls at n+1, MEM at n+2 and WB at n+3.
- Stall cycle: ID/EX ← bubble; EX/MEM and MEM/WB advance normally.
- Taken branch: the 2 younger instructions (in IF/ID and IF) never assert mem_wr_mem or reg_wen_wb. The branch penalty is 2 cycles.
- A load-use stall and a taken branch in EX are mutually exclusive by construction. If both are ever asserted, flush wins.

## Test plan
- Load-use, forwarding path: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333), FWD_EN=1 -> stall_if=1 for exactly 1 cycle, one bubble, fwd_a_ex=1 when add is in EX, stall_cnt=1.
- ALU-to-ALU forwarding: add x3,x1,x2 (0x002081B3) then sub x4,x3,x1 (0x40118233) -> no stall, fwd_a_ex=2, alu_sel_ex=1.
- No-forward mode: the same pair with FWD_EN=0 -> stall_if high for 2 cycles, both fwd selects 0, stall_cnt=2.
- Taken and not-taken branch: BEQ in EX with br_eq_ex=1 -> pc_sel_ex=1 and flush_ifid=1 for 1 cycle, the two following adds never assert reg_wen_wb, flush_cnt=1. The same branch with br_eq_ex=0 -> no flush.
- Illegal and x0 cases: opcode 0x7F with valid_id=1 -> illegal_id=1 and no write 3 cycles later. addi x0,x0,1 followed by a dependent add -> no forwarding and reg_wen_wb=0.
- Reset mid-stream: assert rst while a store is in MEM -> mem_wr_mem falls to 0 immediately, and all outputs and counters read 0.
